// File: rtl/z80_bus_bridge.sv
// Z80 CPU bus to single-port synchronous byte memory bridge.
// Turns held strobes into one-cycle pulses and stalls reads for in-flight data.
module z80_bus_bridge #(
  parameter logic [15:0] WP_TOP = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  input  logic        cpu_mreq_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  input  logic        cpu_rfsh_n,
  output logic        cpu_wait_n,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data_in,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [7:0]  mem_data_out,
  output logic        wp_fault,
  output logic [7:0]  wp_fault_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_CAPT,
    S_RD_HOLD,
    S_WR_HOLD
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_mem_addr;
  logic [15:0] w_mem_addr_nxt;
  logic [7:0]  r_mem_data_in;
  logic [7:0]  w_mem_data_in_nxt;
  logic        r_mem_rd;
  logic        w_mem_rd_nxt;
  logic        r_mem_wr;
  logic        w_mem_wr_nxt;
  logic [7:0]  r_cpu_din;
  logic [7:0]  w_cpu_din_nxt;
  logic        r_wait_n;
  logic        w_wait_n_nxt;
  logic        r_wp_fault;
  logic        w_wp_fault_nxt;
  logic [7:0]  r_wp_cnt;
  logic [7:0]  w_wp_cnt_nxt;

  logic        w_req_ok;
  logic        w_rd_req;
  logic        w_wr_req;
  logic        w_wp_hit;
  logic [16:0] w_addr_p1;

  // Refresh cycles never count; rd+wr together resolves to a read.
  assign w_req_ok = !cpu_mreq_n && cpu_rfsh_n;
  assign w_rd_req = w_req_ok && !cpu_rd_n;
  assign w_wr_req = w_req_ok && cpu_rd_n && !cpu_wr_n;

  // addr < WP_TOP, written so WP_TOP == 0 never matches.
  assign w_addr_p1 = {1'b0, cpu_addr} + 17'd1;
  assign w_wp_hit  = w_addr_p1 <= {1'b0, WP_TOP};

  always_comb begin
    w_state_nxt       = r_state;
    w_mem_addr_nxt    = r_mem_addr;
    w_mem_data_in_nxt = r_mem_data_in;
    w_mem_rd_nxt      = 1'b0;
    w_mem_wr_nxt      = 1'b0;
    w_cpu_din_nxt     = r_cpu_din;
    w_wait_n_nxt      = r_wait_n;
    w_wp_fault_nxt    = 1'b0;
    w_wp_cnt_nxt      = r_wp_cnt;
    case (r_state)
      S_IDLE: begin
        unique case (1'b1)
          w_rd_req: begin
            w_mem_addr_nxt = cpu_addr;
            w_mem_rd_nxt   = 1'b1;
            w_wait_n_nxt   = 1'b0;
            w_state_nxt    = S_RD_ISSUE;
          end
          w_wr_req: begin
            w_mem_addr_nxt    = cpu_addr;
            w_mem_data_in_nxt = cpu_dout;
            if (w_wp_hit) begin
              w_wp_fault_nxt = 1'b1;
              if (r_wp_cnt != 8'hFF)
                w_wp_cnt_nxt = r_wp_cnt + 8'd1;
            end else begin
              w_mem_wr_nxt = 1'b1;
            end
            w_state_nxt = S_WR_HOLD;
          end
          default: ;
        endcase
      end
      S_RD_ISSUE: begin
        w_state_nxt = S_RD_CAPT;
      end
      S_RD_CAPT: begin
        w_cpu_din_nxt = mem_data_out;
        w_wait_n_nxt  = 1'b1;
        w_state_nxt   = S_RD_HOLD;
      end
      S_RD_HOLD: begin
        if (cpu_mreq_n || cpu_rd_n)
          w_state_nxt = S_IDLE;
      end
      S_WR_HOLD: begin
        if (cpu_mreq_n || cpu_wr_n)
          w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_wait_n_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_mem_addr    <= 16'h0000;
      r_mem_data_in <= 8'h00;
      r_mem_rd      <= 1'b0;
      r_mem_wr      <= 1'b0;
      r_cpu_din     <= 8'h00;
      r_wait_n      <= 1'b1;
      r_wp_fault    <= 1'b0;
      r_wp_cnt      <= 8'h00;
    end else begin
      r_state       <= w_state_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
      r_mem_data_in <= w_mem_data_in_nxt;
      r_mem_rd      <= w_mem_rd_nxt;
      r_mem_wr      <= w_mem_wr_nxt;
      r_cpu_din     <= w_cpu_din_nxt;
      r_wait_n      <= w_wait_n_nxt;
      r_wp_fault    <= w_wp_fault_nxt;
      r_wp_cnt      <= w_wp_cnt_nxt;
    end
  end

  assign mem_addr     = r_mem_addr;
  assign mem_data_in  = r_mem_data_in;
  assign mem_rd       = r_mem_rd;
  assign mem_wr       = r_mem_wr;
  assign cpu_din      = r_cpu_din;
  assign cpu_wait_n   = r_wait_n;
  assign wp_fault     = r_wp_fault;
  assign wp_fault_cnt = r_wp_cnt;

endmodule

// File: doc/z80_bus_bridge.md
# z80_bus_bridge

Synchronous bridge between the Z80-style CPU bus (active-low MREQ/RD/WR/RFSH, WAIT) and the single-port byte memory, which has one-cycle registered read latency. Converts level-held CPU strobes into single-cycle memory read/write pulses and stalls the CPU while read data is in flight. Returns captured read data to the CPU and write-protects a parameterised low address window (boot ROM image). All signals are in the `clk` domain; the CPU core is clocked by the same `clk`.

## Interface
Parameters:
- `WP_TOP`, 16'h0000, writes to addresses < `WP_TOP` are blocked; 0 disables protection.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `cpu_addr`  in  16  CPU address bus.
- `cpu_dout`  in  8  CPU write data.
- `cpu_din`  out  8  read data returned to CPU, registered.
- `cpu_mreq_n`, `cpu_rd_n`, `cpu_wr_n`, `cpu_rfsh_n`  in  1 each  CPU bus strobes, active-low.
- `cpu_wait_n`  out  1  stall request to CPU, active-low, registered.
- `mem_addr`  out  16  memory address, registered.
- `mem_data_in`  out  8  memory write data, registered.
- `mem_rd`  out  1  memory read strobe, one-cycle pulse.
- `mem_wr`  out  1  memory write strobe, one-cycle pulse.
- `mem_data_out`  in  8  memory read data (valid one cycle after `mem_addr` is sampled).
- `wp_fault`  out  1  one-cycle pulse on blocked write.
- `wp_fault_cnt`  out  8  saturating count of blocked writes.

## Operation
- Request valid: `cpu_mreq_n`=0 and `cpu_rfsh_n`=1 and (`cpu_rd_n`=0 or `cpu_wr_n`=0). Refresh cycles (`cpu_rfsh_n`=0) are ignored entirely.
- `rd_n` and `wr_n` both low: treated as a read; no write issued.
- FSM states: IDLE, RD_ISSUE, RD_CAPT, RD_HOLD, WR_HOLD.
- IDLE + read request: latch `mem_addr`<=`cpu_addr`, `mem_rd`<=1, `cpu_wait_n`<=0 -> RD_ISSUE.
- RD_ISSUE: `mem_rd`<=0 -> RD_CAPT (memory samples address at this edge).
- RD_CAPT: `cpu_din`<=`mem_data_out`, `cpu_wait_n`<=1 -> RD_HOLD.
- RD_HOLD: hold `cpu_din`; on any edge with `cpu_mreq_n`=1 or `cpu_rd_n`=1 -> IDLE.
- IDLE + write request: latch `mem_addr`, `mem_data_in`<=`cpu_dout`; `mem_wr`<=1 if `cpu_addr` >= `WP_TOP` (unsigned), else `wp_fault`<=1 and `wp_fault_cnt` += 1 (saturates at 255) -> WR_HOLD.
- WR_HOLD: `mem_wr`<=0, `wp_fault`<=0; on edge with `cpu_mreq_n`=1 or `cpu_wr_n`=1 -> IDLE. No wait states on writes.
- A new transaction only starts from IDLE; the CPU must deassert for at least one sampled edge between transactions.
- `mem_addr`/`mem_data_in` hold their last values between transactions.

## Timing
- Reset values: `mem_addr`=0, `mem_data_in`=0, `mem_rd`=0, `mem_wr`=0, `cpu_din`=0, `cpu_wait_n`=1, `wp_fault`=0, `wp_fault_cnt`=0, state IDLE.
- Read: request sampled at edge E0; `mem_rd` high E0->E1; `cpu_din` valid and `cpu_wait_n` high after E2; `cpu_wait_n` low exactly 2 cycles.
- Write: request sampled at E0; `mem_wr` high E0->E1; memory updated at E1; `wp_fault` (if any) high E0->E1.
- `mem_rd` and `mem_wr` are never high in the same cycle and never high more than one cycle per transaction.
- Reset asserted mid-transaction: outputs return to reset values immediately (async); any in-flight write pulse is cut; a request still held after `rst_n` release is treated as new and reissued from IDLE.
- Request deasserting during RD_ISSUE/RD_CAPT: read still completes to RD_HOLD, then exits to IDLE on next edge.

## Test plan
- Memory[0x0003]=0x3E; CPU read 0x0003 -> `mem_rd` pulse 1 cycle, `cpu_wait_n` low 2 cycles, `cpu_din`=0x3E, held until `cpu_rd_n` rises.
- Write 0x5A to 0x8000, then read 0x8000 -> one `mem_wr` pulse with `mem_data_in`=0x5A; read returns 0x5A.
- `WP_TOP`=0x0100; write 0xAA to 0x0005 -> no `mem_wr`, `wp_fault` one-cycle pulse, `wp_fault_cnt`=1; read 0x0005 returns original value; 256 blocked writes -> count stays 255.
- `cpu_mreq_n`=0, `cpu_rd_n`=0, `cpu_rfsh_n`=0 for 4 cycles -> no `mem_rd`, `cpu_wait_n` stays 1.
- Back-to-back reads 0x0000, 0x0001 separated by one idle edge -> two distinct `mem_rd` pulses, correct data each.
- Assert `rst_n`=0 in RD_CAPT -> `cpu_wait_n`=1, `mem_rd`=0, `cpu_din`=0 immediately; release with read still held -> full read reissued with 2-cycle wait.
